// File: rtl/arm_mc_ctrl_if.sv
// Control bus between the multicycle ARM controller and its datapath.
// Controller uses the master view, datapath the slave view.
interface arm_mc_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  Flags;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite,
    output AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
    output ResultSrc, ImmSrc, ALUControl,
    output Flags, State
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite,
    input  AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
    input  ResultSrc, ImmSrc, ALUControl,
    input  Flags, State
  );
endinterface

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM-subset control unit: FSM sequencing,
// condition evaluation, NZCV register and datapath selects.
module arm_mc_ctrl (
  input  logic          clk,
  input  logic          reset,
  arm_mc_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [1:0] A_ADD = 2'b00;
  localparam logic [1:0] A_SUB = 2'b01;
  localparam logic [1:0] A_AND = 2'b10;
  localparam logic [1:0] A_ORR = 2'b11;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  logic n, z, c, v;
  assign {n, z, c, v} = flags_q;

  // Condition check against the registered flags only
  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      4'hF: cond_ex = 1'b0;
    endcase
  end

  // ALU operation for data-processing; unknown cmds become no-write ADD
  logic [1:0] dp_ctl;
  logic       no_write;
  always_comb begin
    dp_ctl   = A_ADD;
    no_write = 1'b0;
    unique case (funct[4:1])
      4'b0100: dp_ctl = A_ADD;
      4'b0010: dp_ctl = A_SUB;
      4'b0000: dp_ctl = A_AND;
      4'b1100: dp_ctl = A_ORR;
      default: no_write = 1'b1;
    endcase
  end

  logic is_exec;
  assign is_exec = (state_q == S_EXECR) |
                   (state_q == S_EXECI);

  // Next state and flag update
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    unique case (state_q)
      S_FETCH:
        if (bus.MemReady) state_d = S_DECODE;
      S_DECODE:
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR:
        state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWRITE:
        if (bus.MemReady) state_d = S_FETCH;
      S_EXECR, S_EXECI:
        state_d = S_ALUWB;
      default:
        state_d = S_FETCH;
    endcase
    if (is_exec & funct[0] & cond_ex & ~no_write) begin
      if (dp_ctl[1])
        flags_d = {bus.ALUFlags[3:2], flags_q[1:0]};
      else
        flags_d = bus.ALUFlags;
    end
  end

  // State and flags registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Moore selects and strobes, strobes blocked during reset
  logic       pc_w, ir_w, reg_w, mem_w;
  logic       adr_src, src_a;
  logic [1:0] src_b, res_src, alu_ctl;
  always_comb begin
    pc_w    = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    adr_src = 1'b0;
    src_a   = 1'b0;
    src_b   = 2'b00;
    res_src = 2'b00;
    alu_ctl = A_ADD;
    unique case (state_q)
      S_FETCH: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
        ir_w    = bus.MemReady;
        pc_w    = bus.MemReady;
      end
      S_DECODE: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
      end
      S_MEMADR: src_b = 2'b01;
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        reg_w   = cond_ex;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = cond_ex;
      end
      S_EXECR: alu_ctl = dp_ctl;
      S_EXECI: begin
        src_b   = 2'b01;
        alu_ctl = dp_ctl;
      end
      S_ALUWB: reg_w = cond_ex & ~no_write;
      S_BRANCH: begin
        src_b   = 2'b01;
        res_src = 2'b10;
        pc_w    = cond_ex;
      end
      default: ;
    endcase
    if (reg_w && rd == 4'hF) pc_w = 1'b1;
    if (!reset) begin
      pc_w  = 1'b0;
      ir_w  = 1'b0;
      reg_w = 1'b0;
      mem_w = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_w;
  assign bus.IRWrite    = ir_w;
  assign bus.RegWrite   = reg_w;
  assign bus.MemWrite   = mem_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = (op == 2'b11) ? 2'b00 : op;
  assign bus.RegSrc[0]  = (op == 2'b10);
  assign bus.RegSrc[1]  = (op == 2'b01) & ~funct[0];
  assign bus.Flags      = flags_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Directed bench for arm_mc_ctrl: reset, DP, flags,
// branches, loads/stores with wait states, mid-op reset.
module tb_arm_mc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  arm_mc_ctrl_if b();

  arm_mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    b.Instr = 20'hE0821;
    b.ALUFlags = 4'b0000;
    b.MemReady = 1'b1;
    #1;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", b.State); end
    total++; if (b.Flags !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", b.Flags); end
    tick;
    total++; if (b.IRWrite !== 1'b0) begin bad++; $display("FAIL rst_irwrite got=%b exp=0", b.IRWrite); end
    total++; if (b.PCWrite !== 1'b0) begin bad++; $display("FAIL rst_pcwrite got=%b exp=0", b.PCWrite); end
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL rst_hold_state got=%0d exp=0", b.State); end
    total++; if (b.ALUSrcB !== 2'b10 || b.ALUSrcA !== 1'b1 || b.ResultSrc !== 2'b10) begin
      bad++; $display("FAIL rst_selects got=%b%b%b exp=11010", b.ALUSrcA, b.ALUSrcB, b.ResultSrc);
    end
    reset = 1'b1;
    #1;
    total++; if (b.IRWrite !== 1'b1) begin bad++; $display("FAIL rel_irwrite got=%b exp=1", b.IRWrite); end
  endtask

  task automatic test_add;
    b.Instr = 20'hE0821;
    b.MemReady = 1'b1;
    #1;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL add_s0 got=%0d exp=0", b.State); end
    total++; if (b.PCWrite !== 1'b1) begin bad++; $display("FAIL add_fetch_pcw got=%b exp=1", b.PCWrite); end
    tick;
    total++; if (b.State !== 4'd1) begin bad++; $display("FAIL add_s1 got=%0d exp=1", b.State); end
    total++; if (b.IRWrite !== 1'b0) begin bad++; $display("FAIL add_dec_irw got=%b exp=0", b.IRWrite); end
    tick;
    total++; if (b.State !== 4'd6) begin bad++; $display("FAIL add_s6 got=%0d exp=6", b.State); end
    total++; if (b.ALUControl !== 2'b00) begin bad++; $display("FAIL add_aluctl got=%b exp=00", b.ALUControl); end
    total++; if (b.RegWrite !== 1'b0) begin bad++; $display("FAIL add_exec_rw got=%b exp=0", b.RegWrite); end
    tick;
    total++; if (b.State !== 4'd8) begin bad++; $display("FAIL add_s8 got=%0d exp=8", b.State); end
    total++; if (b.RegWrite !== 1'b1) begin bad++; $display("FAIL add_wb_rw got=%b exp=1", b.RegWrite); end
    total++; if (b.PCWrite !== 1'b0) begin bad++; $display("FAIL add_wb_pcw got=%b exp=0", b.PCWrite); end
    tick;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL add_end got=%0d exp=0", b.State); end
  endtask

  task automatic do_subs(input logic [3:0] af);
    b.Instr = 20'hE0500;
    b.ALUFlags = af;
    b.MemReady = 1'b1;
    tick;
    tick;
    total++; if (b.ALUControl !== 2'b01) begin bad++; $display("FAIL subs_aluctl got=%b exp=01", b.ALUControl); end
    tick;
    total++; if (b.Flags !== af) begin bad++; $display("FAIL subs_flags got=%b exp=%b", b.Flags, af); end
    tick;
  endtask

  task automatic test_beq(input logic [3:0] af, input logic exp_pcw);
    do_subs(af);
    b.Instr = 20'h0A000;
    tick;
    tick;
    total++; if (b.State !== 4'd9) begin bad++; $display("FAIL beq_state got=%0d exp=9", b.State); end
    total++; if (b.PCWrite !== exp_pcw) begin bad++; $display("FAIL beq_pcw got=%b exp=%b", b.PCWrite, exp_pcw); end
    total++; if (b.RegSrc !== 2'b01) begin bad++; $display("FAIL beq_regsrc got=%b exp=01", b.RegSrc); end
    total++; if (b.ImmSrc !== 2'b10) begin bad++; $display("FAIL beq_immsrc got=%b exp=10", b.ImmSrc); end
    total++; if (b.ALUSrcB !== 2'b01 || b.ResultSrc !== 2'b10) begin
      bad++; $display("FAIL beq_sel got=%b/%b exp=01/10", b.ALUSrcB, b.ResultSrc);
    end
    tick;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL beq_end got=%0d exp=0", b.State); end
  endtask

  task automatic test_ldr;
    b.Instr = 20'hE5912;
    b.MemReady = 1'b1;
    tick;
    tick;
    total++; if (b.State !== 4'd2 || b.ALUSrcB !== 2'b01) begin
      bad++; $display("FAIL ldr_memadr got=%0d/%b exp=2/01", b.State, b.ALUSrcB);
    end
    total++; if (b.ImmSrc !== 2'b01 || b.RegSrc !== 2'b00) begin
      bad++; $display("FAIL ldr_dec got=%b/%b exp=01/00", b.ImmSrc, b.RegSrc);
    end
    b.MemReady = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b.MemReady = 1'b1;
      #1;
      total++; if (b.State !== 4'd3 || b.AdrSrc !== 1'b1) begin
        bad++; $display("FAIL ldr_wait%0d got=%0d/%b exp=3/1", i, b.State, b.AdrSrc);
      end
      tick;
    end
    total++; if (b.State !== 4'd4) begin bad++; $display("FAIL ldr_s4 got=%0d exp=4", b.State); end
    total++; if (b.ResultSrc !== 2'b01 || b.RegWrite !== 1'b1) begin
      bad++; $display("FAIL ldr_wb got=%b/%b exp=01/1", b.ResultSrc, b.RegWrite);
    end
    tick;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL ldr_end got=%0d exp=0", b.State); end
  endtask

  task automatic test_str;
    b.Instr = 20'hE5812;
    b.MemReady = 1'b1;
    tick;
    tick;
    total++; if (b.RegSrc !== 2'b10 || b.ImmSrc !== 2'b01) begin
      bad++; $display("FAIL str_dec got=%b/%b exp=10/01", b.RegSrc, b.ImmSrc);
    end
    b.MemReady = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) b.MemReady = 1'b1;
      #1;
      total++; if (b.State !== 4'd5 || b.MemWrite !== 1'b1 || b.RegWrite !== 1'b0) begin
        bad++; $display("FAIL str_wait%0d got=%0d/%b/%b exp=5/1/0", i, b.State, b.MemWrite, b.RegWrite);
      end
      tick;
    end
    total++; if (b.State !== 4'd0 || b.MemWrite !== 1'b0) begin
      bad++; $display("FAIL str_end got=%0d/%b exp=0/0", b.State, b.MemWrite);
    end
  endtask

  task automatic test_ands;
    do_subs(4'b0011);
    b.Instr = 20'hE0100;
    b.ALUFlags = 4'b1000;
    tick;
    tick;
    total++; if (b.ALUControl !== 2'b10 || b.Flags !== 4'b0011) begin
      bad++; $display("FAIL ands_exec got=%b/%b exp=10/0011", b.ALUControl, b.Flags);
    end
    tick;
    total++; if (b.Flags !== 4'b1011) begin bad++; $display("FAIL ands_flags got=%b exp=1011", b.Flags); end
    tick;
  endtask

  task automatic test_addne;
    do_subs(4'b0100);
    b.Instr = 20'h10821;
    tick;
    tick;
    tick;
    total++; if (b.State !== 4'd8 || b.RegWrite !== 1'b0) begin
      bad++; $display("FAIL addne_rw got=%0d/%b exp=8/0", b.State, b.RegWrite);
    end
    tick;
    b.Instr = 20'h10921;
    b.ALUFlags = 4'b1011;
    tick;
    tick;
    tick;
    total++; if (b.Flags !== 4'b0100) begin bad++; $display("FAIL addsne_flags got=%b exp=0100", b.Flags); end
    tick;
  endtask

  task automatic test_nowrite;
    b.Instr = 20'hE1B00;
    b.ALUFlags = 4'b1111;
    tick;
    tick;
    total++; if (b.ALUControl !== 2'b00) begin bad++; $display("FAIL nowr_aluctl got=%b exp=00", b.ALUControl); end
    tick;
    total++; if (b.RegWrite !== 1'b0 || b.Flags !== 4'b0100) begin
      bad++; $display("FAIL nowr_wb got=%b/%b exp=0/0100", b.RegWrite, b.Flags);
    end
    tick;
  endtask

  task automatic test_pc_wb_op11;
    b.Instr = 20'hE082F;
    tick;
    tick;
    tick;
    total++; if (b.RegWrite !== 1'b1 || b.PCWrite !== 1'b1) begin
      bad++; $display("FAIL r15_wb got=%b/%b exp=1/1", b.RegWrite, b.PCWrite);
    end
    tick;
    b.Instr = 20'hEC000;
    tick;
    total++; if (b.State !== 4'd1 || b.ImmSrc !== 2'b00) begin
      bad++; $display("FAIL op11_dec got=%0d/%b exp=1/00", b.State, b.ImmSrc);
    end
    tick;
    total++; if (b.State !== 4'd0) begin bad++; $display("FAIL op11_end got=%0d exp=0", b.State); end
  endtask

  task automatic test_reset_mid;
    b.Instr = 20'hE5812;
    b.MemReady = 1'b1;
    tick;
    tick;
    b.MemReady = 1'b0;
    tick;
    #1;
    total++; if (b.MemWrite !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", b.MemWrite); end
    reset = 1'b0;
    #1;
    total++; if (b.MemWrite !== 1'b0 || b.State !== 4'd0) begin
      bad++; $display("FAIL mid_async got=%b/%0d exp=0/0", b.MemWrite, b.State);
    end
    total++; if (b.Flags !== 4'b0000) begin bad++; $display("FAIL mid_flags got=%b exp=0000", b.Flags); end
    #2;
    reset = 1'b1;
    b.MemReady = 1'b1;
    b.Instr = 20'hEC000;
    #1;
    total++; if (b.IRWrite !== 1'b1) begin bad++; $display("FAIL mid_resume got=%b exp=1", b.IRWrite); end
    tick;
    total++; if (b.State !== 4'd1) begin bad++; $display("FAIL mid_decode got=%0d exp=1", b.State); end
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_beq(4'b0110, 1'b1);
    test_beq(4'b0000, 1'b0);
    test_ldr;
    test_str;
    test_ands;
    test_addne;
    test_nowrite;
    test_pc_wb_op11;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
